// File: rtl/ms_ctrl.sv
// Minesweeper game controller: sequences place/load/decode/alu/display commands around player guesses.
// Optional MS_CTRL_TIMEOUT_EN adds a wait-state watchdog that forces OVER after TIMEOUT cycles.
module ms_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic       clka,
  input  logic       restart_n,
  input  logic       new_game,
  input  logic       guess_valid,
  input  logic [4:0] guess_data,
  input  logic       place_done,
  input  logic       decode_done,
  input  logic       alu_done,
  input  logic       display_done,
  input  logic       gameover,
  input  logic       win,
  output logic       start,
  output logic       load,
  output logic       decode,
  output logic       alu,
  output logic       display,
  output logic [4:0] data,
  output logic       guess_ready,
  output logic       bad_guess,
  output logic       game_over,
  output logic       won,
  output logic [4:0] moves,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PLACE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_LOAD   = 3'd3;
  localparam logic [2:0] S_DECODE = 3'd4;
  localparam logic [2:0] S_EVAL   = 3'd5;
  localparam logic [2:0] S_SHOW   = 3'd6;
  localparam logic [2:0] S_OVER   = 3'd7;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("ms_ctrl: TIMEOUT must be within 2..255");
  end

  logic [2:0] state_q, state_d;
  logic [4:0] data_q, data_d, moves_q, moves_d;
  logic       go_q, go_d, won_q, won_d, bad_q, bad_d;
  logic       start_q, load_q, decode_q, alu_q, display_q, rdy_q;

`ifdef MS_CTRL_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       waiting, tmo;

  assign waiting = (state_q == S_PLACE) || (state_q == S_DECODE) ||
                   (state_q == S_EVAL)  || (state_q == S_SHOW);
  assign tmo     = waiting && (cnt_q == TO_LAST);

  always_comb begin
    cnt_d = 8'd0;
    if (waiting && (state_d == state_q)) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) cnt_q <= 8'd0;
    else            cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    moves_d = moves_q;
    go_d    = go_q;
    won_d   = won_q;
    bad_d   = 1'b0;
    case (state_q)
      S_IDLE:   if (new_game) state_d = S_PLACE;
      S_PLACE:
        if (place_done) begin
          state_d = S_WAIT;
          moves_d = 5'd0;
          go_d    = 1'b0;
          won_d   = 1'b0;
        end
      S_WAIT: begin
        // A new game request outranks a guess offered in the same cycle
        if (new_game) begin
          state_d = S_PLACE;
        end else if (guess_valid) begin
          if (guess_data < 5'd25) begin
            state_d = S_LOAD;
            data_d  = guess_data;
            if (moves_q != 5'd31) moves_d = moves_q + 5'd1;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      S_LOAD:   state_d = S_DECODE;
      S_DECODE: if (decode_done) state_d = S_EVAL;
      S_EVAL:
        if (alu_done) begin
          state_d = S_SHOW;
          go_d    = gameover;
          won_d   = win;
        end
      S_SHOW:   if (display_done) state_d = go_q ? S_OVER : S_WAIT;
      default:  if (new_game) state_d = S_PLACE;
    endcase
`ifdef MS_CTRL_TIMEOUT_EN
    // Completion seen on the final allowed cycle still wins over the watchdog
    if (tmo && (state_d == state_q)) begin
      state_d = S_OVER;
      go_d    = 1'b1;
      won_d   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q   <= S_IDLE;
      data_q    <= 5'd0;
      moves_q   <= 5'd0;
      go_q      <= 1'b0;
      won_q     <= 1'b0;
      bad_q     <= 1'b0;
      start_q   <= 1'b0;
      load_q    <= 1'b0;
      decode_q  <= 1'b0;
      alu_q     <= 1'b0;
      display_q <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      moves_q   <= moves_d;
      go_q      <= go_d;
      won_q     <= won_d;
      bad_q     <= bad_d;
      // Commands are decoded from the next state so each is a clean register output
      start_q   <= (state_d == S_PLACE);
      load_q    <= (state_d == S_LOAD);
      decode_q  <= (state_d == S_DECODE);
      alu_q     <= (state_d == S_EVAL);
      display_q <= (state_d == S_SHOW);
      rdy_q     <= (state_d == S_WAIT);
    end
  end

  assign start       = start_q;
  assign load        = load_q;
  assign decode      = decode_q;
  assign alu         = alu_q;
  assign display     = display_q;
  assign data        = data_q;
  assign guess_ready = rdy_q;
  assign bad_guess   = bad_q;
  assign game_over   = go_q;
  assign won         = won_q;
  assign moves       = moves_q;
  assign state       = state_q;

endmodule

// File: tb/tb_ms_ctrl.sv
// Randomized bench for ms_ctrl: a responder plays the datapath, a monitor scores outputs against queued expectations.
module tb_ms_ctrl;
  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic restart_n, new_game, guess_valid;
  logic [4:0] guess_data;
  logic place_done, decode_done, alu_done, display_done, gameover, win;
  logic start, load, decode, alu, display, guess_ready, bad_guess, game_over, won;
  logic [4:0] data, moves;
  logic [2:0] state;

  ms_ctrl #(.TIMEOUT(4)) dut (
    .clka(clka), .restart_n(restart_n), .new_game(new_game),
    .guess_valid(guess_valid), .guess_data(guess_data),
    .place_done(place_done), .decode_done(decode_done), .alu_done(alu_done),
    .display_done(display_done), .gameover(gameover), .win(win),
    .start(start), .load(load), .decode(decode), .alu(alu), .display(display),
    .data(data), .guess_ready(guess_ready), .bad_guess(bad_guess),
    .game_over(game_over), .won(won), .moves(moves), .state(state)
  );

  typedef struct { logic [4:0] d; logic [4:0] m; } guess_t;
  typedef struct { logic go; logic w; } res_t;

  guess_t gq[$];
  int     bq[$];
  int     len_q[$];
  res_t   rq[$];

  int checks = 0;
  int failures = 0;
  int fixed_lat = -1;
  bit alu_hang = 0;
  bit no_over = 0;
  bit force_win = 0;
  bit mon_en = 0;
  int model_moves = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got nothing, required an event", name);
  endtask

  // Datapath stand-in: picks a completion latency per command and records the expected length/result
  initial begin
    int prev, cur, cnt, lat;
    prev = 0; cnt = 0; lat = 0;
    {place_done, decode_done, alu_done, display_done, gameover, win} = '0;
    forever begin
      @(negedge clka);
      cur = start ? 1 : decode ? 2 : alu ? 3 : display ? 4 : 0;
      if (!restart_n) begin
        prev = 0;
        {place_done, decode_done, alu_done, display_done} = '0;
      end else begin
        if (cur != prev) begin
          cnt = 0;
          lat = (cur == 3 && alu_hang) ? 1000 :
                (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 2));
          if (cur != 0 && mon_en) len_q.push_back(lat + 1);
        end else begin
          cnt++;
        end
        place_done   = (cur == 1) && (cnt >= lat);
        decode_done  = (cur == 2) && (cnt >= lat);
        alu_done     = (cur == 3) && (cnt >= lat);
        display_done = (cur == 4) && (cnt >= lat);
        if (cur == 3 && cnt == lat) begin
          if (force_win) begin
            gameover = 1'b1; win = 1'b1;
          end else begin
            gameover = no_over ? 1'b0 : ($urandom_range(0, 7) == 0);
            win      = gameover & 1'($urandom_range(0, 1));
          end
          if (mon_en) rq.push_back('{gameover, win});
        end
        prev = cur;
      end
    end
  end

  // Monitor: scores command lengths, captured guesses, bad-guess pulses and game results
  initial begin
    int cur, mprev, mrun;
    guess_t g;
    res_t r;
    mprev = 0; mrun = 0;
    forever begin
      @(negedge clka);
      if (mon_en && restart_n) begin
        cur = start ? 1 : decode ? 2 : alu ? 3 : display ? 4 : load ? 5 : 0;
        chk("cmd_onehot", 32'($countones({start, load, decode, alu, display}) <= 1), 1);
        if (cur != mprev) begin
          if (mprev == 5) chk("load_len", mrun, 1);
          else if (mprev != 0) begin
            if (len_q.size() == 0) miss("cmd_len_unexpected");
            else chk("cmd_len", mrun, len_q.pop_front());
          end
          if (mprev == 4) begin
            if (rq.size() == 0) miss("result_unexpected");
            else begin
              r = rq.pop_front();
              chk("game_over", game_over, r.go);
              chk("won", won, r.w);
              chk("state_after_show", state, r.go ? 7 : 2);
            end
          end
          if (cur == 5) begin
            chk("ready_in_load", guess_ready, 0);
            if (gq.size() == 0) miss("load_unexpected");
            else begin
              g = gq.pop_front();
              chk("data", data, g.d);
              chk("moves", moves, g.m);
            end
          end
          mrun = 1;
        end else begin
          mrun++;
        end
        if (bad_guess) begin
          if (bq.size() == 0) miss("bad_guess_unexpected");
          else begin
            chk("bad_moves", moves, bq.pop_front());
            chk("bad_state", state, 2);
          end
        end
        mprev = cur;
      end else begin
        mprev = 0;
        mrun = 0;
      end
    end
  end

  task automatic wait_ready_or_over(output bit over);
    over = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clka);
      if (guess_ready) return;
      if (state == 3'd7) begin over = 1; return; end
    end
    miss("wait_ready_timeout");
  endtask

  task automatic new_game_seq(output int scnt);
    bit got;
    new_game = 1'b1;
    @(negedge clka);
    new_game = 1'b0;
    model_moves = 0;
    scnt = 0; got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (guess_ready) got = 1;
      else begin
        if (start) scnt++;
        @(negedge clka);
      end
    end
    if (!got) miss("place_timeout");
    chk("place_moves", moves, 0);
    chk("place_game_over", game_over, 0);
    chk("place_won", won, 0);
    chk("place_state", state, 2);
  endtask

  task automatic guess(input logic [4:0] gd);
    guess_valid = 1'b1;
    guess_data  = gd;
    if (gd < 25) begin
      if (model_moves < 31) model_moves++;
      if (mon_en) gq.push_back('{gd, 5'(model_moves)});
    end else if (mon_en) begin
      bq.push_back(model_moves);
    end
    @(negedge clka);
    guess_valid = 1'b0;
    if (gd >= 25) begin
      @(negedge clka);
      chk("bad_pulse_width", bad_guess, 0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit over;
    int n;
    restart_n = 1'b0; new_game = 1'b0; guess_valid = 1'b0; guess_data = 5'd0;
    repeat (3) @(negedge clka);
    chk("rst_state", state, 0);
    chk("rst_cmds", {start, load, decode, alu, display}, 0);
    chk("rst_data", data, 0);
    chk("rst_moves", moves, 0);
    chk("rst_flags", {game_over, won, bad_guess, guess_ready}, 0);
    restart_n = 1'b1;
    @(negedge clka);
    chk("idle_after_rst", state, 0);
    mon_en = 1;

    fixed_lat = 2;
    new_game_seq(n);
    chk("start_cycles", n, 3);

    fixed_lat = 0; no_over = 1;
    wait_ready_or_over(over);
    guess(5'd7);
    wait_ready_or_over(over);
    chk("guess7_back_to_wait", over, 0);

    force_win = 1;
    guess(5'd12);
    wait_ready_or_over(over);
    chk("guess12_over", over, 1);
    force_win = 0;

    new_game_seq(n);
    guess(5'd25);
    wait_ready_or_over(over);
    guess(5'd30);
    wait_ready_or_over(over);
    new_game = 1'b1; guess_valid = 1'b1; guess_data = 5'd3;
    @(negedge clka);
    new_game = 1'b0; guess_valid = 1'b0;
    chk("newgame_priority_state", state, 1);
    chk("newgame_priority_noload", load, 0);
    model_moves = 0;
    wait_ready_or_over(over);
    chk("newgame_priority_moves", moves, 0);

    fixed_lat = -1; no_over = 0;
    for (int it = 0; it < 150; it++) begin
      wait_ready_or_over(over);
      if (over || $urandom_range(0, 19) == 0) new_game_seq(n);
      else guess(5'($urandom_range(0, 31)));
    end

    wait_ready_or_over(over);
    new_game_seq(n);
    no_over = 1;
    for (int it = 0; it < 33; it++) begin
      wait_ready_or_over(over);
      guess(5'($urandom_range(0, 24)));
    end
    wait_ready_or_over(over);
    chk("moves_saturate", moves, 31);
    chk("queue_guess_empty", gq.size(), 0);
    chk("queue_bad_empty", bq.size(), 0);
    chk("queue_len_empty", len_q.size(), 0);
    chk("queue_res_empty", rq.size(), 0);

    fixed_lat = 20;
    guess(5'd5);
    n = 0;
    while (!decode && n < 50) begin n++; @(negedge clka); end
    chk("decode_reached", decode, 1);
    #2;
    mon_en = 0;
    restart_n = 1'b0;
    #1;
    chk("midrst_cmds", {start, load, decode, alu, display}, 0);
    chk("midrst_state", state, 0);
    chk("midrst_regs", {data, moves, game_over, won, bad_guess, guess_ready}, 0);
    repeat (2) @(negedge clka);
    restart_n = 1'b1;
    @(negedge clka);
    chk("post_rst_state", state, 0);
    chk("post_rst_cmds", {start, load, decode, alu, display}, 0);
    gq.delete(); bq.delete(); len_q.delete(); rq.delete();

    fixed_lat = 0; alu_hang = 1; no_over = 1;
    new_game_seq(n);
    guess(5'd9);
    n = 0;
    while (!alu && n < 50) begin n++; @(negedge clka); end
    n = 0;
    while (alu && n < 10) begin n++; @(negedge clka); end
`ifdef MS_CTRL_TIMEOUT_EN
    chk("timeout_alu_cycles", n, 4);
    chk("timeout_state", state, 7);
    chk("timeout_game_over", game_over, 1);
    chk("timeout_won", won, 0);
    chk("timeout_cmds", {start, load, decode, alu, display}, 0);
`else
    chk("hold_alu_cycles", n, 10);
    chk("hold_state", state, 5);
    chk("hold_alu", alu, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
